fetch_decode_execute: RTL and testbench
=======================================

FETCH_DECODE_EXECUTE -- requirements
Module: fetch_decode_execute

Interface
REQ-001 The block SHALL have parameter BASE_ADDR, default 32'h80020000, which is the reset PC and instruction-memory base.
REQ-002 The block SHALL have parameter MEM_DEPTH, default 32'h00100000, which is the memory size in bytes and is used for the stack-pointer reset value.
REQ-003 The block SHALL have port clock, input, 1 bit: the single clock; all state updates on its posedge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port stall, input, 1 bit: freezes PC and the DX register.
REQ-006 The block SHALL have port insn, input, 32 bits: instruction word returned for address.
REQ-007 The block SHALL have ports wb_we (input, 1 bit), wb_reg (input, 5 bits) and wb_data (input, 32 bits): register-file write port.
REQ-008 The block SHALL have port address, output, 32 bits: instruction fetch address, equal to the PC.
REQ-009 The block SHALL have ports access_size (output, 2 bits, constant 2'b10 = word), rw (output, 1 bit, constant 0 = read) and i_mem_enable (output, 1 bit, 0 in reset, else 1).
REQ-010 The block SHALL have port pc_out, output, 32 bits: PC of the instruction in decode.
REQ-011 The block SHALL have ports br, jp, aluinb, dmwe, rwe, rdst, rwd (output, 1 bit each) and aluop (output, 6 bits): execute-stage (DX) controls.
REQ-012 The block SHALL have ports alu_out (output, 32 bits), rb_out (output, 32 bits: store data) and dest_reg (output, 5 bits).

Function
REQ-013 Fetch SHALL update PC on posedge, unless stall is high, as follows: PC <= redirect target when the DX instruction is a taken branch or jump, else PC + 4.
REQ-014 Decode SHALL be combinational from insn and the register file; rA = R[insn[25:21]], rB = R[insn[20:16]], and R0 SHALL always read 0.
REQ-015 Register writes SHALL occur on posedge when wb_we=1 and wb_reg!=0.
REQ-016 Controls SHALL be set as follows: aluinb=1 for immediate ops, LW, SW; rdst=1 (dest = rt) for I-type; rwd=1 for LW; dmwe=1 for SW; rwe=1 for ALU ops, LW, JAL; br=1 for BEQ, BNE, BLEZ, BGTZ; jp=1 for J, JAL, JR.
REQ-017 aluop SHALL carry the R-type funct, or the equivalent funct for I-type ops (ADDIU->ADDU, SLTI->SLT, ANDI->AND, and so on); 6'h00 with insn=0 is a NOP with all controls 0.
REQ-018 The supported set SHALL be ADD(U), SUB(U), AND, OR, XOR, NOR, SLT(U), SLL, SRL, SRA, SLLV, SRLV, SRAV, ADDI(U), SLTI(U), ANDI, ORI, XORI, LUI, LW, SW, BEQ, BNE, BLEZ, BGTZ, J, JAL, JR; unsupported opcodes decode as NOP.
REQ-019 On posedge with stall=0, the DX register SHALL capture pc, insn, rA, rB and all controls; with stall=1 it SHALL hold.
REQ-020 Execute SHALL be combinational from DX.
REQ-021 Immediates SHALL be sign-extended, except ANDI/ORI/XORI which are zero-extended and LUI which is imm<<16.
REQ-022 Arithmetic SHALL be 32-bit modulo with no overflow trap; shifts use shamt, or rs[4:0] for the V forms; SLT is signed and SLTU is unsigned.
REQ-023 LW/SW alu_out SHALL be rA + sext(imm), and rb_out SHALL be rB.
REQ-024 The branch target SHALL be pc+4+(sext(imm)<<2); the J/JAL target SHALL be {pc+4[31:28], insn[25:0], 2'b00}; the JR target SHALL be rA.
REQ-025 JAL SHALL set alu_out = pc+8 and dest_reg = 31.
REQ-026 One delay slot SHALL apply: the instruction after a branch or jump always executes, and no flush is performed.
REQ-027 If stall and redirect occur together, the redirect SHALL be deferred until stall is low.

Reset
REQ-028 Reset SHALL set PC = BASE_ADDR, clear DX to NOP (all outputs 0), and drive i_mem_enable = 0.
REQ-029 Reset SHALL set registers R[i] = 0, except R29 = BASE_ADDR + MEM_DEPTH and R31 = 32'hdeadbeef.
REQ-030 When reset is deasserted mid-operation, fetch SHALL resume at BASE_ADDR on the next posedge.

Configuration
REQ-031 With FDX_RF_BYPASS_EN defined, a decode read of the register being written in the same cycle SHALL return wb_data.
REQ-032 Without FDX_RF_BYPASS_EN, such a read SHALL return the old value.

Verification
REQ-033 Reset release -> address 0x80020000 then 0x80020004 and 0x80020008 on successive posedges; R29 = 0x80120000.
REQ-034 ADDIU $3,$0,5 (0x24030005) -> one cycle later alu_out = 5, dest_reg = 3, rwe = 1, rdst = 1.
REQ-035 BEQ $0,$0,+4 at 0x80020010 -> delay slot 0x80020014 is decoded, and the next address is 0x80020024.
REQ-036 stall=1 for 3 cycles -> address and DX outputs are unchanged; fetch resumes +4 after stall drops.
REQ-037 With wb_we=1, wb_reg=8, wb_data=0x1234 in the same cycle that decode reads $8 -> rA = 0x1234 with the macro defined, and the old value without it.
REQ-038 JAL 0x0008000 at 0x80020000 -> alu_out = 0x80020008, dest_reg = 31, next address 0x80020000 | 0x20000.

Source files
------------

// File: rtl/fetch_decode_execute.sv
`default_nettype none
// ============================================================================
// Module      : fetch_decode_execute
// Description : Fetch, decode and execute stages for a MIPS-subset core.
//               The fetch stage holds the PC and drives the instruction-memory
//               address. Decode is combinational from the returned instruction
//               and the register file. The DX register feeds a combinational
//               execute stage that computes the ALU result and the branch or
//               jump redirect. There is one architectural delay slot and no
//               flush.
// Ports       : clock, reset (async, active-high), stall
//               insn          - instruction word for address
//               wb_we/wb_reg/wb_data - register-file write port
//               address, access_size, rw, i_mem_enable - fetch interface
//               pc_out        - PC of the instruction in decode
//               br, jp, aluinb, dmwe, rwe, rdst, rwd, aluop - DX controls
//               alu_out, rb_out, dest_reg - execute results
// Option      : FDX_RF_BYPASS_EN - decode reads of the register being written
//               in the same cycle return wb_data.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_decode_execute #(
  parameter logic [31:0] BASE_ADDR = 32'h80020000,
  parameter logic [31:0] MEM_DEPTH = 32'h00100000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic [31:0] insn,
  input  logic        wb_we,
  input  logic [4:0]  wb_reg,
  input  logic [31:0] wb_data,
  output logic [31:0] address,
  output logic [1:0]  access_size,
  output logic        rw,
  output logic        i_mem_enable,
  output logic [31:0] pc_out,
  output logic        br,
  output logic        jp,
  output logic        aluinb,
  output logic        dmwe,
  output logic        rwe,
  output logic        rdst,
  output logic        rwd,
  output logic [5:0]  aluop,
  output logic [31:0] alu_out,
  output logic [31:0] rb_out,
  output logic [4:0]  dest_reg
);

  localparam logic [5:0] OP_SPECIAL = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03;
  localparam logic [5:0] OP_BEQ = 6'h04, OP_BNE = 6'h05, OP_BLEZ = 6'h06, OP_BGTZ = 6'h07;
  localparam logic [5:0] OP_ADDI = 6'h08, OP_ADDIU = 6'h09, OP_SLTI = 6'h0a, OP_SLTIU = 6'h0b;
  localparam logic [5:0] OP_ANDI = 6'h0c, OP_ORI = 6'h0d, OP_XORI = 6'h0e, OP_LUI = 6'h0f;
  localparam logic [5:0] OP_LW = 6'h23, OP_SW = 6'h2b;

  localparam logic [5:0] FN_SLL = 6'h00, FN_SRL = 6'h02, FN_SRA = 6'h03, FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06, FN_SRAV = 6'h07, FN_JR = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20, FN_ADDU = 6'h21, FN_SUB = 6'h22, FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND = 6'h24, FN_OR = 6'h25, FN_XOR = 6'h26, FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2a, FN_SLTU = 6'h2b;

  localparam logic [31:0] SP_RESET = BASE_ADDR + MEM_DEPTH;

  // ---------------------------------------------------------------- fetch
  logic [31:0] pc;
  logic        redirect;
  logic [31:0] redirect_target;

  // A redirect held in DX during a stall is naturally deferred: DX is frozen,
  // so the redirect is still pending when stall drops.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)       pc <= BASE_ADDR;
    else if (!stall) pc <= redirect ? redirect_target : pc + 32'd4;
  end

  assign address      = pc;
  assign pc_out       = pc;
  assign access_size  = 2'b10;
  assign rw           = 1'b0;
  assign i_mem_enable = ~reset;

  // -------------------------------------------------------- register file
  logic [31:0] regs [32];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
      regs[29] <= SP_RESET;
      regs[31] <= 32'hdeadbeef;
    end else if (wb_we && wb_reg != 5'd0) begin
      regs[wb_reg] <= wb_data;
    end
  end

  // --------------------------------------------------------------- decode
  logic [4:0]  rs, rt;
  logic [31:0] rf_a, rf_b;
  assign rs = insn[25:21];
  assign rt = insn[20:16];

`ifdef FDX_RF_BYPASS_EN
  assign rf_a = (rs == 5'd0) ? 32'd0 : (wb_we && wb_reg == rs) ? wb_data : regs[rs];
  assign rf_b = (rt == 5'd0) ? 32'd0 : (wb_we && wb_reg == rt) ? wb_data : regs[rt];
`else
  assign rf_a = (rs == 5'd0) ? 32'd0 : regs[rs];
  assign rf_b = (rt == 5'd0) ? 32'd0 : regs[rt];
`endif

  logic       dec_valid, dec_imm;
  logic       dec_br, dec_jp, dec_aluinb, dec_dmwe, dec_rwe, dec_rdst, dec_rwd;
  logic [5:0] dec_aluop;

  always_comb begin
    dec_valid  = 1'b1;
    dec_imm    = 1'b0;
    dec_br     = 1'b0;
    dec_jp     = 1'b0;
    dec_aluinb = 1'b0;
    dec_dmwe   = 1'b0;
    dec_rwe    = 1'b0;
    dec_rdst   = 1'b0;
    dec_rwd    = 1'b0;
    dec_aluop  = 6'h00;
    case (insn[31:26])
      OP_SPECIAL: begin
        case (insn[5:0])
          FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR, FN_XOR, FN_NOR,
          FN_SLT, FN_SLTU, FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV: begin
            dec_rwe   = 1'b1;
            dec_aluop = insn[5:0];
          end
          FN_JR: begin
            dec_jp    = 1'b1;
            dec_aluop = insn[5:0];
          end
          default: dec_valid = 1'b0;
        endcase
      end
      OP_J:   dec_jp = 1'b1;
      OP_JAL: begin dec_jp = 1'b1; dec_rwe = 1'b1; end
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: begin dec_br = 1'b1; dec_rdst = 1'b1; end
      OP_ADDI:  begin dec_imm = 1'b1; dec_aluop = FN_ADD;  end
      OP_ADDIU: begin dec_imm = 1'b1; dec_aluop = FN_ADDU; end
      OP_SLTI:  begin dec_imm = 1'b1; dec_aluop = FN_SLT;  end
      OP_SLTIU: begin dec_imm = 1'b1; dec_aluop = FN_SLTU; end
      OP_ANDI:  begin dec_imm = 1'b1; dec_aluop = FN_AND;  end
      OP_ORI:   begin dec_imm = 1'b1; dec_aluop = FN_OR;   end
      OP_XORI:  begin dec_imm = 1'b1; dec_aluop = FN_XOR;  end
      // LUI ORs the shifted immediate onto a forced-zero A operand in execute.
      OP_LUI:   begin dec_imm = 1'b1; dec_aluop = FN_OR;   end
      OP_LW:    begin dec_imm = 1'b1; dec_rwd = 1'b1; dec_aluop = FN_ADDU; end
      OP_SW: begin
        dec_aluinb = 1'b1;
        dec_rdst   = 1'b1;
        dec_dmwe   = 1'b1;
        dec_aluop  = FN_ADDU;
      end
      default: dec_valid = 1'b0;
    endcase
    if (dec_imm) begin
      dec_aluinb = 1'b1;
      dec_rdst   = 1'b1;
      dec_rwe    = 1'b1;
    end
    if (insn == 32'd0) dec_valid = 1'b0;
  end

  // ----------------------------------------------------------- DX register
  logic [31:0] dx_pc, dx_insn, dx_ra, dx_rb;

  // Unsupported words are captured as an all-zero instruction so that every
  // execute output of a NOP is zero.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dx_pc   <= 32'd0;
      dx_insn <= 32'd0;
      dx_ra   <= 32'd0;
      dx_rb   <= 32'd0;
      br      <= 1'b0;
      jp      <= 1'b0;
      aluinb  <= 1'b0;
      dmwe    <= 1'b0;
      rwe     <= 1'b0;
      rdst    <= 1'b0;
      rwd     <= 1'b0;
      aluop   <= 6'h00;
    end else if (!stall) begin
      dx_pc   <= pc;
      dx_insn <= dec_valid ? insn : 32'd0;
      dx_ra   <= dec_valid ? rf_a : 32'd0;
      dx_rb   <= dec_valid ? rf_b : 32'd0;
      br      <= dec_valid & dec_br;
      jp      <= dec_valid & dec_jp;
      aluinb  <= dec_valid & dec_aluinb;
      dmwe    <= dec_valid & dec_dmwe;
      rwe     <= dec_valid & dec_rwe;
      rdst    <= dec_valid & dec_rdst;
      rwd     <= dec_valid & dec_rwd;
      aluop   <= dec_valid ? dec_aluop : 6'h00;
    end
  end

  // -------------------------------------------------------------- execute
  logic [5:0]  dx_op;
  logic [31:0] imm_ext, sext_imm, opa, opb, dx_pc4;
  logic [4:0]  shamt;
  logic        taken;

  assign dx_op    = dx_insn[31:26];
  assign sext_imm = {{16{dx_insn[15]}}, dx_insn[15:0]};
  assign dx_pc4   = dx_pc + 32'd4;
  assign rb_out   = dx_rb;

  always_comb begin
    case (dx_op)
      OP_ANDI, OP_ORI, OP_XORI: imm_ext = {16'h0000, dx_insn[15:0]};
      OP_LUI:                   imm_ext = {dx_insn[15:0], 16'h0000};
      default:                  imm_ext = sext_imm;
    endcase
    opa   = (dx_op == OP_LUI) ? 32'd0 : dx_ra;
    opb   = aluinb ? imm_ext : dx_rb;
    shamt = (aluop == FN_SLLV || aluop == FN_SRLV || aluop == FN_SRAV) ? dx_ra[4:0]
                                                                       : dx_insn[10:6];
    case (aluop)
      FN_ADD, FN_ADDU:  alu_out = opa + opb;
      FN_SUB, FN_SUBU:  alu_out = opa - opb;
      FN_AND:           alu_out = opa & opb;
      FN_OR:            alu_out = opa | opb;
      FN_XOR:           alu_out = opa ^ opb;
      FN_NOR:           alu_out = ~(opa | opb);
      FN_SLT:           alu_out = {31'd0, $signed(opa) < $signed(opb)};
      FN_SLTU:          alu_out = {31'd0, opa < opb};
      FN_SLL, FN_SLLV:  alu_out = opb << shamt;
      FN_SRL, FN_SRLV:  alu_out = opb >> shamt;
      FN_SRA, FN_SRAV:  alu_out = $signed(opb) >>> shamt;
      default:          alu_out = 32'd0;
    endcase
    // JAL links past its delay slot.
    if (jp && dx_op == OP_JAL) alu_out = dx_pc + 32'd8;

    if (jp && dx_op == OP_JAL) dest_reg = 5'd31;
    else if (rdst)             dest_reg = dx_insn[20:16];
    else                       dest_reg = dx_insn[15:11];
  end

  always_comb begin
    case (dx_op)
      OP_BEQ:  taken = (dx_ra == dx_rb);
      OP_BNE:  taken = (dx_ra != dx_rb);
      OP_BLEZ: taken = ($signed(dx_ra) <= 32'sd0);
      OP_BGTZ: taken = ($signed(dx_ra) >  32'sd0);
      default: taken = 1'b0;
    endcase
    taken = taken & br;

    if (br)                  redirect_target = dx_pc4 + {sext_imm[29:0], 2'b00};
    else if (dx_op == OP_SPECIAL) redirect_target = dx_ra;
    else                     redirect_target = {dx_pc4[31:28], dx_insn[25:0], 2'b00};

    redirect = taken | jp;
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_decode_execute.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_decode_execute
// Description : Self-checking bench for fetch_decode_execute. Combines a table
//               of known-answer decode/execute vectors, hand-written pipeline
//               sequences (reset, branch delay slot, stall, JAL, bypass) and a
//               randomized run checked against an instruction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_decode_execute;

  localparam logic [31:0] BASE = 32'h80020000;

  logic        clock, reset, stall, wb_we;
  logic [31:0] insn, wb_data;
  logic [4:0]  wb_reg;
  logic [31:0] address, pc_out, alu_out, rb_out;
  logic [1:0]  access_size;
  logic        rw, i_mem_enable, br, jp, aluinb, dmwe, rwe, rdst, rwd;
  logic [5:0]  aluop;
  logic [4:0]  dest_reg;

  fetch_decode_execute dut (
    .clock(clock), .reset(reset), .stall(stall), .insn(insn),
    .wb_we(wb_we), .wb_reg(wb_reg), .wb_data(wb_data),
    .address(address), .access_size(access_size), .rw(rw),
    .i_mem_enable(i_mem_enable), .pc_out(pc_out),
    .br(br), .jp(jp), .aluinb(aluinb), .dmwe(dmwe), .rwe(rwe),
    .rdst(rdst), .rwd(rwd), .aluop(aluop),
    .alu_out(alu_out), .rb_out(rb_out), .dest_reg(dest_reg)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [12:0] dut_ctrl();
    return {br, jp, aluinb, dmwe, rwe, rdst, rwd, aluop};
  endfunction

  // ------------------------------------------------ instruction-level model
  typedef struct packed {
    logic        br, jp, aluinb, dmwe, rwe, rdst, rwd;
    logic [5:0]  aluop;
    logic [31:0] alu;
    logic [31:0] rb;
    logic [4:0]  dest;
    logic        chk_alu;
    logic        redirect;
    logic [31:0] target;
  } mdx_t;

  logic [31:0] m_regs [32];
  logic [31:0] m_pc;
  mdx_t        m_dx;

  function automatic mdx_t model_dx(input logic [31:0] pc, input logic [31:0] ins,
                                    input logic [31:0] ra, input logic [31:0] rb);
    mdx_t e;
    logic [31:0] se, ze, pc4;
    logic [4:0]  rt, rd, sh;
    e   = '0;
    se  = {{16{ins[15]}}, ins[15:0]};
    ze  = {16'h0000, ins[15:0]};
    pc4 = pc + 32'd4;
    rt  = ins[20:16];
    rd  = ins[15:11];
    sh  = ins[10:6];
    if (ins == 32'd0) return e;
    e.rb = rb;
    e.chk_alu = 1'b1;
    if (ins[31:26] == 6'h00) begin
      e.aluop = ins[5:0]; e.dest = rd; e.rwe = 1'b1;
      case (ins[5:0])
        6'h20, 6'h21: e.alu = ra + rb;
        6'h22, 6'h23: e.alu = ra - rb;
        6'h24: e.alu = ra & rb;
        6'h25: e.alu = ra | rb;
        6'h26: e.alu = ra ^ rb;
        6'h27: e.alu = ~(ra | rb);
        6'h2a: e.alu = ($signed(ra) < $signed(rb)) ? 32'd1 : 32'd0;
        6'h2b: e.alu = (ra < rb) ? 32'd1 : 32'd0;
        6'h00: e.alu = rb << sh;
        6'h02: e.alu = rb >> sh;
        6'h03: e.alu = $signed(rb) >>> sh;
        6'h04: e.alu = rb << ra[4:0];
        6'h06: e.alu = rb >> ra[4:0];
        6'h07: e.alu = $signed(rb) >>> ra[4:0];
        6'h08: begin
          e.rwe = 1'b0; e.jp = 1'b1; e.chk_alu = 1'b0;
          e.redirect = 1'b1; e.target = ra;
        end
        default: e = '0;
      endcase
      return e;
    end
    e.dest = rt;
    case (ins[31:26])
      6'h02, 6'h03: begin
        e.jp = 1'b1; e.redirect = 1'b1; e.chk_alu = 1'b0;
        e.target = {pc4[31:28], ins[25:0], 2'b00};
        if (ins[31:26] == 6'h03) begin
          e.rwe = 1'b1; e.dest = 5'd31; e.alu = pc + 32'd8; e.chk_alu = 1'b1;
        end
      end
      6'h04, 6'h05, 6'h06, 6'h07: begin
        e.br = 1'b1; e.rdst = 1'b1; e.chk_alu = 1'b0;
        e.target = pc4 + (se << 2);
        case (ins[31:26])
          6'h04:   e.redirect = (ra == rb);
          6'h05:   e.redirect = (ra != rb);
          6'h06:   e.redirect = ($signed(ra) <= 0);
          default: e.redirect = ($signed(ra) > 0);
        endcase
      end
      6'h08: begin e.alu = ra + se; e.aluop = 6'h20; end
      6'h09: begin e.alu = ra + se; e.aluop = 6'h21; end
      6'h0a: begin e.alu = ($signed(ra) < $signed(se)) ? 32'd1 : 32'd0; e.aluop = 6'h2a; end
      6'h0b: begin e.alu = (ra < se) ? 32'd1 : 32'd0; e.aluop = 6'h2b; end
      6'h0c: begin e.alu = ra & ze; e.aluop = 6'h24; end
      6'h0d: begin e.alu = ra | ze; e.aluop = 6'h25; end
      6'h0e: begin e.alu = ra ^ ze; e.aluop = 6'h26; end
      6'h0f: begin e.alu = {ins[15:0], 16'h0000}; e.aluop = 6'h25; end
      6'h23: begin e.alu = ra + se; e.aluop = 6'h21; e.rwd = 1'b1; end
      6'h2b: begin e.alu = ra + se; e.aluop = 6'h21; e.dmwe = 1'b1; e.aluinb = 1'b1; e.rdst = 1'b1; end
      default: e = '0;
    endcase
    if (ins[31:26] inside {6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f, 6'h23}) begin
      e.aluinb = 1'b1; e.rdst = 1'b1; e.rwe = 1'b1;
    end
    return e;
  endfunction

  function automatic logic [31:0] mread(input logic [4:0] idx, input logic we,
                                        input logic [4:0] wr, input logic [31:0] wd);
    if (idx == 5'd0) return 32'd0;
`ifdef FDX_RF_BYPASS_EN
    if (we && wr == idx) return wd;
`endif
    return m_regs[idx];
  endfunction

  task automatic model_check();
    chk("address", address, m_pc);
    chk("pc_out", pc_out, m_pc);
    chk("ctrl", {19'd0, dut_ctrl()},
        {19'd0, m_dx.br, m_dx.jp, m_dx.aluinb, m_dx.dmwe, m_dx.rwe, m_dx.rdst, m_dx.rwd, m_dx.aluop});
    chk("rb_out", rb_out, m_dx.rb);
    if (m_dx.chk_alu) begin
      chk("alu_out", alu_out, m_dx.alu);
      chk("dest_reg", {27'd0, dest_reg}, {27'd0, m_dx.dest});
    end
  endtask

  // One clock: drive inputs, let the edge happen, advance the model, compare.
  task automatic cycle(input logic [31:0] i, input logic st, input logic we,
                       input logic [4:0] wr, input logic [31:0] wd);
    mdx_t nd;
    insn = i; stall = st; wb_we = we; wb_reg = wr; wb_data = wd;
    nd = model_dx(m_pc, i, mread(i[25:21], we, wr, wd), mread(i[20:16], we, wr, wd));
    @(posedge clock);
    #1;
    if (!st) begin
      m_pc = m_dx.redirect ? m_dx.target : m_pc + 32'd4;
      m_dx = nd;
    end
    if (we && wr != 5'd0) m_regs[wr] = wd;
    model_check();
  endtask

  task automatic nop(input logic st);
    cycle(32'd0, st, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; insn = 32'd0; stall = 1'b0; wb_we = 1'b0; wb_reg = 5'd0; wb_data = 32'd0;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_regs[29] = 32'h80120000;
    m_regs[31] = 32'hdeadbeef;
    m_pc = BASE;
    m_dx = '0;
    #1;
    chk("rst address", address, 32'h80020000);
    chk("rst i_mem_enable", {31'd0, i_mem_enable}, 32'd0);
    chk("rst ctrl", {19'd0, dut_ctrl()}, 32'd0);
    chk("rst alu_out", alu_out, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("post-rst i_mem_enable", {31'd0, i_mem_enable}, 32'd1);
    chk("post-rst address", address, 32'h80020000);
    chk("access_size/rw", {29'd0, access_size, rw}, 32'd4);
  endtask

  // ----------------------------------------------------- known-answer table
  typedef struct {
    string       name;
    logic [31:0] insn, alu, rb;
    logic [4:0]  dest;
    logic [6:0]  flags;   // br jp aluinb dmwe rwe rdst rwd
    logic [5:0]  aluop;
  } vec_t;

  vec_t vq[$];

  task automatic add_vec(input string n, input logic [31:0] i, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] d, input logic [6:0] f,
                         input logic [5:0] op);
    vec_t v;
    v.name = n; v.insn = i; v.alu = a; v.rb = b; v.dest = d; v.flags = f; v.aluop = op;
    vq.push_back(v);
  endtask

  localparam logic [5:0] FN_LIST [17] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26,
      6'h27, 6'h2a, 6'h2b, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08};
  localparam logic [5:0] OP_LIST [17] = '{6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07, 6'h08,
      6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f, 6'h23, 6'h2b, 6'h3f};

  function automatic logic [31:0] rand_insn();
    logic [31:0] r;
    int k;
    r = $urandom();
    k = $urandom_range(0, 20);
    r[25:21] = 5'($urandom_range(0, 7));
    r[20:16] = 5'($urandom_range(0, 7));
    if (k < 7) begin
      r[31:26] = 6'h00;
      r[5:0]   = (k == 0) ? 6'h01 : FN_LIST[$urandom_range(0, 16)];
    end else begin
      r[31:26] = OP_LIST[$urandom_range(0, 16)];
    end
    return r;
  endfunction

  initial begin
    reset = 1'b1; stall = 1'b0; insn = 32'd0; wb_we = 1'b0; wb_reg = 5'd0; wb_data = 32'd0;

    // Reset release, sequential fetch and the stack-pointer reset value.
    do_reset();
    nop(1'b0);
    chk("fetch +4", address, 32'h80020004);
    nop(1'b0);
    chk("fetch +8", address, 32'h80020008);
    cycle(32'h03A00821, 1'b0, 1'b0, 5'd0, 32'd0);          // ADDU $1,$29,$0
    chk("R29 reset", alu_out, 32'h80120000);
    cycle(32'h24030005, 1'b0, 1'b0, 5'd0, 32'd0);          // ADDIU $3,$0,5
    chk("addiu alu_out", alu_out, 32'd5);
    chk("addiu dest/rwe/rdst", {25'd0, dest_reg, rwe, rdst}, {25'd0, 5'd3, 1'b1, 1'b1});

    // Taken branch with its delay slot.
    do_reset();
    repeat (4) nop(1'b0);
    chk("pre-branch address", address, 32'h80020010);
    cycle(32'h10000004, 1'b0, 1'b0, 5'd0, 32'd0);          // BEQ $0,$0,+4
    chk("beq br", {31'd0, br}, 32'd1);
    chk("delay-slot address", address, 32'h80020014);
    cycle(32'h24030007, 1'b0, 1'b0, 5'd0, 32'd0);          // delay slot ADDIU $3,$0,7
    chk("branch target", address, 32'h80020024);
    chk("delay slot executed", alu_out, 32'd7);

    // Stall freezes PC and DX; a pending redirect waits for the stall to drop.
    for (int s = 0; s < 3; s++) begin
      cycle(32'h24030009, 1'b1, 1'b0, 5'd0, 32'd0);
      chk("stall address", address, 32'h80020024);
      chk("stall alu_out", alu_out, 32'd7);
    end
    cycle(32'h10000004, 1'b0, 1'b0, 5'd0, 32'd0);          // BEQ at 0x80020024
    chk("resume +4", address, 32'h80020028);
    nop(1'b1);
    nop(1'b1);
    chk("deferred redirect", address, 32'h80020028);
    nop(1'b0);
    chk("redirect after stall", address, 32'h80020038);

    // Same-cycle write and read of $8.
    cycle(32'd0, 1'b0, 1'b1, 5'd8, 32'h00000055);
    cycle(32'h01000821, 1'b0, 1'b1, 5'd8, 32'h00001234);   // ADDU $1,$8,$0
`ifdef FDX_RF_BYPASS_EN
    chk("rf bypass", alu_out, 32'h00001234);
`else
    chk("rf no bypass", alu_out, 32'h00000055);
`endif

    // JAL from the reset PC.
    do_reset();
    cycle(32'h0C008000, 1'b0, 1'b0, 5'd0, 32'd0);          // JAL 0x0008000
    chk("jal link", alu_out, 32'h80020008);
    chk("jal dest", {27'd0, dest_reg}, 32'd31);
    chk("jal delay-slot address", address, 32'h80020004);
    nop(1'b0);
    chk("jal target", address, 32'h80020000);

    // Known-answer vectors with R8 = 0x1234, R9 = 0xfffffff0, R29 = 0x80120000.
    do_reset();
    cycle(32'd0, 1'b0, 1'b1, 5'd8, 32'h00001234);
    cycle(32'd0, 1'b0, 1'b1, 5'd9, 32'hfffffff0);
    add_vec("addiu", 32'h24030005, 32'h00000005, 32'h00000000, 5'd3,  7'b0010110, 6'h21);
    add_vec("addu",  32'h01095021, 32'h00001224, 32'hfffffff0, 5'd10, 7'b0000100, 6'h21);
    add_vec("subu",  32'h01095023, 32'h00001244, 32'hfffffff0, 5'd10, 7'b0000100, 6'h23);
    add_vec("slt",   32'h0128502a, 32'h00000001, 32'h00001234, 5'd10, 7'b0000100, 6'h2a);
    add_vec("sltu",  32'h0128502b, 32'h00000000, 32'h00001234, 5'd10, 7'b0000100, 6'h2b);
    add_vec("sra",   32'h00095103, 32'hffffffff, 32'hfffffff0, 5'd10, 7'b0000100, 6'h03);
    add_vec("srl",   32'h00095102, 32'h0fffffff, 32'hfffffff0, 5'd10, 7'b0000100, 6'h02);
    add_vec("andi",  32'h31248001, 32'h00008000, 32'h00000000, 5'd4,  7'b0010110, 6'h24);
    add_vec("addi",  32'h2104fffc, 32'h00001230, 32'h00000000, 5'd4,  7'b0010110, 6'h20);
    add_vec("lui",   32'h3c05abcd, 32'habcd0000, 32'h00000000, 5'd5,  7'b0010110, 6'h25);
    add_vec("lw",    32'h8fa60008, 32'h80120008, 32'h00000000, 5'd6,  7'b0010111, 6'h21);
    add_vec("sw",    32'hafa8fffc, 32'h8011fffc, 32'h00001234, 5'd8,  7'b0011010, 6'h21);
    add_vec("nor",   32'h01005027, 32'hffffedcb, 32'h00000000, 5'd10, 7'b0000100, 6'h27);
    add_vec("unsup", 32'hfd095021, 32'h00000000, 32'h00000000, 5'd0,  7'b0000000, 6'h00);
    add_vec("sllv",  32'h01095004, 32'hff000000, 32'hfffffff0, 5'd10, 7'b0000100, 6'h04);
    for (int v = 0; v < vq.size(); v++) begin
      cycle(vq[v].insn, 1'b0, 1'b0, 5'd0, 32'd0);
      chk($sformatf("%s alu_out", vq[v].name), alu_out, vq[v].alu);
      chk($sformatf("%s rb_out", vq[v].name), rb_out, vq[v].rb);
      chk($sformatf("%s dest_reg", vq[v].name), {27'd0, dest_reg}, {27'd0, vq[v].dest});
      chk($sformatf("%s ctrl", vq[v].name), {19'd0, dut_ctrl()}, {19'd0, vq[v].flags, vq[v].aluop});
    end

    // Randomized instruction stream, stalls and write-backs.
    do_reset();
    for (int k = 0; k < 400; k++) begin
      cycle(rand_insn(), ($urandom_range(0, 4) == 0), ($urandom_range(0, 1) == 1),
            5'($urandom_range(0, 7)), $urandom());
    end

    // Reset mid-operation restarts fetch from the base address.
    do_reset();
    nop(1'b0);
    chk("restart +4", address, 32'h80020004);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
